hypercpu_fetch: RTL
===================

Name: hypercpu_fetch

Overview:
Instruction fetch stage of hypercpu, directly upstream of decode and the consumer of the program ROM read port. Drives the word address and read enable on the instruction memory bus, and captures the combinational read data in the same cycle. Buffers fetched words with their PCs in a small in-order queue and hands them to decode over a valid/ready handshake. Honours PC redirects (jumps, or writes to $pc) from execute by flushing the queue.

Parameters:
ADDR_W, 32, width of mem_addr and of every PC value
DATA_W, 32, instruction word width
DEPTH, 2, instruction queue entries (power of two, >=2)
RESET_PC, 32'h0, first fetch address after reset

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
mem_addr  output  ADDR_W  word address to instruction memory; always equals fetch_pc
mem_read_enabled  output  1  high = fetch issued this cycle; memory drives mem_read
mem_read  input  DATA_W  instruction word, combinational from mem_addr; tristate when not enabled
bus_busy  input  1  data side owns the memory bus this cycle; fetch must not issue
redirect_valid  input  1  one-cycle PC redirect request from execute
redirect_pc  input  ADDR_W  new fetch address
instr_valid  output  1  queue head is valid
instr  output  DATA_W  queue head instruction word
instr_pc  output  ADDR_W  address the head word was fetched from
instr_ready  input  1  decode accepts head this cycle

Behaviour:
- State: fetch_pc (ADDR_W), queue storage DEPTH x (DATA_W+ADDR_W), rd_ptr, wr_ptr, count (0..DEPTH).
- Reset (sampled at edge): fetch_pc<=RESET_PC, count<=0, rd_ptr<=0, wr_ptr<=0. While reset is high: mem_read_enabled=0, instr_valid=0, mem_addr=fetch_pc. instr and instr_pc are don't-care while instr_valid=0.
- pop = instr_valid & instr_ready.
- issue (combinational) = !reset & !bus_busy & !redirect_valid & (count<DEPTH | pop).
- mem_read_enabled = issue.
- On an issue cycle:
  - at the edge, push {mem_read, fetch_pc} at wr_ptr;
  - fetch_pc <= fetch_pc+1, wrapping modulo 2^ADDR_W (word addressing; 32'hFFFFFFFF -> 0).
- mem_read is sampled only when mem_read_enabled=1. The Z value on other cycles is never captured.
- Count update: push only -> +1; pop only -> -1; both -> unchanged. Pointers wrap modulo DEPTH.
- Full queue with a pop in the same cycle: issue is allowed, and the queue stays full.
- Latency: a word issued in cycle N appears at the queue head (instr_valid=1) in cycle N+1 if the queue was empty. There is no combinational bypass from mem_read to instr.
- Redirect (redirect_valid=1) has priority over everything except reset:
  - no issue that cycle;
  - at the edge, count<=0, rd_ptr<=wr_ptr (queue flushed), fetch_pc<=redirect_pc;
  - a pop in the same cycle is still an accepted handshake for decode, but its effect on the queue is superseded by the flush;
  - the first fetch of redirect_pc occurs in cycle N+1 at the earliest.
- Back-to-back redirects: the last one wins; no fetch happens between them.
- bus_busy=1: no issue; fetch_pc holds; the queue can still drain.
- instr, instr_pc and instr_valid must remain stable while instr_valid=1 and instr_ready=0.
- Reset mid-operation discards all queued words. The first fetch after reset deasserts is at RESET_PC.

Test Plan:
- Free run, instr_ready=1, bus_busy=0, ROM program loaded:
  - mem_addr 0,1,2,… on consecutive cycles;
  - decode receives (pc 0, 32'hfc3100fa), (pc 1, 32'h9cf80002), (pc 2, 32'hfcff0002), one per cycle starting 1 cycle after the first issue.
- Backpressure: instr_ready=0 for 5 cycles.
  - Exactly DEPTH=2 issues (pc 0,1), then mem_read_enabled=0 and fetch_pc holds at 2.
  - Head stays (0, 32'hfc3100fa).
  - Release ready: order is 0,1,2 with no loss or duplication.
- bus_busy=1 on cycles 3–4 of the run: mem_read_enabled=0 in those cycles, with no gap in PC sequence and no duplicate word delivered to decode.
- Redirect while the queue holds pc 0x0b/0x0c, with redirect_pc=0x0a in the same cycle as a pop:
  - next cycle instr_valid=0 and mem_addr=0x0a;
  - decode then sees (0x0a, 32'h9c900011), (0x0b, 32'hec010000).
- Wrap: redirect_pc=32'hFFFFFFFF, then fetch addresses FFFFFFFF, 00000000, 00000001, with matching instr_pc.
- Reset asserted for 1 cycle with the queue full at pc 5/6:
  - during reset, instr_valid=0 and mem_read_enabled=0;
  - after reset, first delivered word is (pc 0, 32'hfc3100fa).

Source files
------------

// File: rtl/hypercpu_fetch.sv
// Instruction fetch stage: issues word fetches to the program ROM and buffers
// {instr, pc} pairs in a small in-order queue feeding decode over valid/ready.
module hypercpu_fetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read_enabled,
  input  logic [DATA_W-1:0] mem_read,
  input  logic              bus_busy,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [DATA_W-1:0] r_q_data [DEPTH];
  logic [ADDR_W-1:0] r_q_pc   [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_valid;
  logic w_pop;
  logic w_issue;

  always_comb begin
    w_valid = !reset && (r_count != '0);
    w_pop   = w_valid && instr_ready;
    // A pop frees a slot in the same cycle, so a full queue can still issue.
    w_issue = !reset && !bus_busy && !redirect_valid &&
              ((r_count < CNT_W'(DEPTH)) || w_pop);
  end

  assign mem_addr         = r_fetch_pc;
  assign mem_read_enabled = w_issue;
  assign instr_valid      = w_valid;
  assign instr            = r_q_data[r_rd_ptr];
  assign instr_pc         = r_q_pc[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else if (redirect_valid) begin
      // Flush supersedes any same-cycle pop.
      r_fetch_pc <= redirect_pc;
      r_count    <= '0;
      r_rd_ptr   <= r_wr_ptr;
    end else begin
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
        r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_issue, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_q_data[r_wr_ptr] <= mem_read;
      r_q_pc[r_wr_ptr]   <= r_fetch_pc;
    end
  end

endmodule
